l1i_miss_handler: RTL and testbench

- Responder side of the L1I miss/update interface: accepts a miss (address, PID, TID, instruction major ID) from the L1 instruction cache and requests the line from the next memory level.
- Assembles the returned beats into a full cacheline and returns it to the cache as a single-cycle update.
- Handles one outstanding miss at a time. Misses arriving while busy are dropped and flagged.

---
 rtl/l1i_miss_handler.sv | 137 +++++++++++++
 tb/tb_l1i_miss_handler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1i_miss_handler.sv
// l1i_miss_handler
//   Serves L1 instruction-cache misses, one at a time. A miss is captured in
//   IDLE with its address aligned to the line. The line is requested from the
//   next memory level and assembled from memBeatWidth-wide beats. It is then
//   returned to the cache as a single-cycle update strobe. A miss that arrives
//   while a fill is in flight is dropped, and droppedMiss_o flags it.
//
//   Bit numbering is big-endian throughout: beat k lands in line bits
//   [k*memBeatWidth : (k+1)*memBeatWidth-1], so beat 0 is the most
//   significant part of the line.
//
// Ports
//   clock_i, reset_i            clock (rising edge), synchronous active-high reset
//   cacheMiss_i, missed*_i      miss request and its address/ID/PID/TID
//   busy_o                      a miss is being serviced (state != IDLE)
//   droppedMiss_o               pulse: a miss arrived while busy last cycle
//   memReq_o, memReqAddress_o   line read request, held until memReqAck_i
//   memReqAck_i                 request accepted
//   memDataValid_i, memData_i   returned beats
//   cacheUpdate_o, cacheUpdate*_o  one-cycle line update; payload holds afterwards
module l1i_miss_handler #(
   parameter int fetchingAddressWidth    = 64,
   parameter int cacheLineWith           = 512,
   parameter int offsetWidth             = 6,
   parameter int memBeatWidth            = 64,  // must divide cacheLineWith exactly
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64
) (
   input  logic                                clock_i,
   input  logic                                reset_i,
   input  logic                                cacheMiss_i,
   input  logic [0:fetchingAddressWidth-1]     missedAddress_i,
   input  logic [0:instructionCounterWidth-1]  missedInstMajorId_i,
   input  logic [0:PidSize-1]                  missedPid_i,
   input  logic [0:TidSize-1]                  missedTid_i,
   output logic                                busy_o,
   output logic                                droppedMiss_o,
   output logic                                memReq_o,
   output logic [0:fetchingAddressWidth-1]     memReqAddress_o,
   input  logic                                memReqAck_i,
   input  logic                                memDataValid_i,
   input  logic [0:memBeatWidth-1]             memData_i,
   output logic                                cacheUpdate_o,
   output logic [0:fetchingAddressWidth-1]     cacheUpdateAddress_o,
   output logic [0:cacheLineWith-1]            cacheUpdateLine_o,
   output logic [0:PidSize-1]                  cacheUpdatePid_o,
   output logic [0:TidSize-1]                  cacheUpdateTid_o,
   output logic [0:instructionCounterWidth-1]  cacheUpdateInstMajorId_o
);

   localparam int beatsPerLine = cacheLineWith / memBeatWidth;
   localparam int cntWidth     = (beatsPerLine > 1) ? $clog2(beatsPerLine) : 1;

   // Clears the line-offset bits of the captured address.
   localparam logic [0:fetchingAddressWidth-1] offset_mask =
      {{(fetchingAddressWidth-offsetWidth){1'b0}}, {offsetWidth{1'b1}}};

   typedef enum logic [1:0] {IDLE, REQ, FILL, UPDATE} state_t;

   state_t                               state, state_next;
   logic [cntWidth-1:0]                  beat_cnt;
   logic                                 last_beat;
   logic [0:fetchingAddressWidth-1]      addr_q;
   logic [0:PidSize-1]                   pid_q;
   logic [0:TidSize-1]                   tid_q;
   logic [0:instructionCounterWidth-1]   id_q;
   logic [0:cacheLineWith-1]             line_q;
   logic                                 dropped_q;

   assign last_beat = (beat_cnt == cntWidth'(beatsPerLine - 1));

   always_comb begin
      state_next    = state;
      busy_o        = (state != IDLE);
      memReq_o      = 1'b0;
      cacheUpdate_o = 1'b0;
      case (state)
         IDLE:   if (cacheMiss_i) state_next = REQ;
         REQ: begin
            memReq_o = 1'b1;
            if (memReqAck_i) state_next = FILL;
         end
         FILL:   if (memDataValid_i && last_beat) state_next = UPDATE;
         UPDATE: begin
            cacheUpdate_o = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         addr_q    <= '0;
         pid_q     <= '0;
         tid_q     <= '0;
         id_q      <= '0;
         line_q    <= '0;
         dropped_q <= 1'b0;
      end else begin
         state     <= state_next;
         dropped_q <= cacheMiss_i && (state != IDLE);
         case (state)
            IDLE: if (cacheMiss_i) begin
               addr_q <= missedAddress_i & ~offset_mask;
               pid_q  <= missedPid_i;
               tid_q  <= missedTid_i;
               id_q   <= missedInstMajorId_i;
            end
            REQ: if (memReqAck_i) beat_cnt <= '0;
            FILL: if (memDataValid_i) begin
               for (int k = 0; k < beatsPerLine; k++)
                  if (beat_cnt == cntWidth'(k))
                     line_q[k*memBeatWidth +: memBeatWidth] <= memData_i;
               // The last beat leaves FILL, so the counter restarts at 0
               // rather than wrapping into a live slot.
               beat_cnt <= last_beat ? '0 : beat_cnt + cntWidth'(1);
            end
            default: ;
         endcase
      end
   end

   // Update payload is the captured miss context; it stays valid after the
   // strobe until the next accepted miss overwrites it.
   assign droppedMiss_o            = dropped_q;
   assign memReqAddress_o          = addr_q;
   assign cacheUpdateAddress_o     = addr_q;
   assign cacheUpdateLine_o        = line_q;
   assign cacheUpdatePid_o         = pid_q;
   assign cacheUpdateTid_o         = tid_q;
   assign cacheUpdateInstMajorId_o = id_q;

endmodule

// File: tb/tb_l1i_miss_handler.sv
module tb_l1i_miss_handler;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          cacheMiss_i = 1'b0;
   logic [63:0]   missedAddress_i = '0;
   logic [63:0]   missedInstMajorId_i = '0;
   logic [19:0]   missedPid_i = '0;
   logic [15:0]   missedTid_i = '0;
   logic          busy_o, droppedMiss_o, memReq_o, cacheUpdate_o;
   logic [63:0]   memReqAddress_o, cacheUpdateAddress_o, cacheUpdateInstMajorId_o;
   logic          memReqAck_i = 1'b0;
   logic          memDataValid_i = 1'b0;
   logic [63:0]   memData_i = '0;
   logic [511:0]  cacheUpdateLine_o;
   logic [19:0]   cacheUpdatePid_o;
   logic [15:0]   cacheUpdateTid_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] beats [8];

   l1i_miss_handler dut (
      .clock_i(clock_i), .reset_i(reset_i), .cacheMiss_i(cacheMiss_i),
      .missedAddress_i(missedAddress_i), .missedInstMajorId_i(missedInstMajorId_i),
      .missedPid_i(missedPid_i), .missedTid_i(missedTid_i),
      .busy_o(busy_o), .droppedMiss_o(droppedMiss_o),
      .memReq_o(memReq_o), .memReqAddress_o(memReqAddress_o), .memReqAck_i(memReqAck_i),
      .memDataValid_i(memDataValid_i), .memData_i(memData_i),
      .cacheUpdate_o(cacheUpdate_o), .cacheUpdateAddress_o(cacheUpdateAddress_o),
      .cacheUpdateLine_o(cacheUpdateLine_o), .cacheUpdatePid_o(cacheUpdatePid_o),
      .cacheUpdateTid_o(cacheUpdateTid_o), .cacheUpdateInstMajorId_o(cacheUpdateInstMajorId_o)
   );

   always #5 clock_i = ~clock_i;

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   // Expected line: beat 0 is the most significant 64 bits.
   function automatic logic [511:0] exp_line();
      logic [511:0] l = '0;
      for (int i = 0; i < 8; i++) l = {l[447:0], beats[i]};
      return l;
   endfunction

   task automatic fill_beats(input logic [63:0] base);
      for (int i = 0; i < 8; i++) beats[i] = base + 64'(i);
   endtask

   task automatic present_miss(input logic [63:0] a, input logic [19:0] p,
                               input logic [15:0] t, input logic [63:0] id);
      cacheMiss_i = 1'b1; missedAddress_i = a; missedPid_i = p;
      missedTid_i = t; missedInstMajorId_i = id;
      step();
      cacheMiss_i = 1'b0;
   endtask

   task automatic ack_now();
      memReqAck_i = 1'b1;
      step();
      memReqAck_i = 1'b0;
   endtask

   // Drives beats[first..last] with 'gap' idle cycles between them; counts
   // update strobes seen before the final beat edge.
   task automatic send_beats(input int first, input int last, input int gap,
                             output int early);
      early = 0;
      for (int i = first; i <= last; i++) begin
         if (i > first)
            for (int g = 0; g < gap; g++) begin
               memDataValid_i = 1'b0;
               step();
               if (cacheUpdate_o) early++;
            end
         memDataValid_i = 1'b1; memData_i = beats[i];
         step();
         if (i < last && cacheUpdate_o) early++;
      end
      memDataValid_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      step(); step();
      n_checks++;
      if ({busy_o, droppedMiss_o, memReq_o, cacheUpdate_o} !== 4'b0 ||
          memReqAddress_o !== 64'h0 || cacheUpdateLine_o !== 512'h0 ||
          cacheUpdatePid_o !== 20'h0 || cacheUpdateTid_o !== 16'h0 ||
          cacheUpdateInstMajorId_o !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_state: flags=%b addr=%h pid=%h", {busy_o, droppedMiss_o, memReq_o, cacheUpdate_o}, memReqAddress_o, cacheUpdatePid_o);
      end
      reset_i = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int early;
      beats = '{64'hAAAAAAAA_BBBBBBBB, 64'hCCCCCCCC_DDDDDDDD, 64'hEEEEEEEE_FFFFFFFF,
                64'h11111111_22222222, 64'h33333333_44444444, 64'h55555555_66666666,
                64'h77777777_88888888, 64'h99999999_00000000};
      present_miss(64'h28, 20'd3, 16'd1, 64'h11);
      n_checks++;
      if (memReq_o !== 1'b1 || memReqAddress_o !== 64'h0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_req: memReq=%b addr=%h busy=%b, expected 1/0/1", memReq_o, memReqAddress_o, busy_o);
      end
      ack_now();
      n_checks++;
      if (memReq_o !== 1'b0) begin
         n_fail++; $display("FAIL basic_req_drop: memReq=%b expected 0", memReq_o);
      end
      send_beats(0, 7, 0, early);
      n_checks++;
      if (cacheUpdate_o !== 1'b1 || early != 0) begin
         n_fail++; $display("FAIL basic_strobe: upd=%b early=%0d expected 1/0", cacheUpdate_o, early);
      end
      n_checks++;
      if (cacheUpdateLine_o !== exp_line() || cacheUpdateLine_o[511:448] !== 64'hAAAAAAAA_BBBBBBBB) begin
         n_fail++; $display("FAIL basic_line: got %h expected %h", cacheUpdateLine_o, exp_line());
      end
      n_checks++;
      if (cacheUpdateAddress_o !== 64'h0 || cacheUpdatePid_o !== 20'd3 ||
          cacheUpdateTid_o !== 16'd1 || cacheUpdateInstMajorId_o !== 64'h11) begin
         n_fail++;
         $display("FAIL basic_ctx: addr=%h pid=%h tid=%h id=%h expected 0/3/1/11", cacheUpdateAddress_o, cacheUpdatePid_o, cacheUpdateTid_o, cacheUpdateInstMajorId_o);
      end
      step();
      n_checks++;
      if (cacheUpdate_o !== 1'b0 || busy_o !== 1'b0 || cacheUpdatePid_o !== 20'd3) begin
         n_fail++; $display("FAIL basic_after: upd=%b busy=%b pid=%h expected 0/0/3", cacheUpdate_o, busy_o, cacheUpdatePid_o);
      end
   endtask

   task automatic test_ack_delay();
      int early, bad;
      bad = 0;
      fill_beats(64'h0123_4567_0000_0000);
      present_miss(64'h1234_5678_9ABC_DEFF, 20'hABCDE, 16'h7777, 64'h22);
      // Five REQ cycles without ack, junk beats offered; sixth cycle acks.
      for (int c = 0; c < 6; c++) begin
         if (memReq_o !== 1'b1 || memReqAddress_o !== 64'h1234_5678_9ABC_DEC0) bad++;
         memDataValid_i = 1'b1; memData_i = 64'hDEAD_0000_0000_0000 + 64'(c);
         memReqAck_i = (c == 5);
         step();
      end
      memReqAck_i = 1'b0; memDataValid_i = 1'b0;
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL delay_req_hold: %0d unstable REQ cycles, expected 0", bad);
      end
      send_beats(0, 7, 0, early);
      n_checks++;
      if (cacheUpdate_o !== 1'b1 || cacheUpdateLine_o !== exp_line() ||
          cacheUpdateAddress_o !== 64'h1234_5678_9ABC_DEC0) begin
         n_fail++; $display("FAIL delay_line: upd=%b line=%h addr=%h", cacheUpdate_o, cacheUpdateLine_o, cacheUpdateAddress_o);
      end
      step();
   endtask

   task automatic test_gaps();
      int early;
      fill_beats(64'hFEED_0000_0000_0010);
      present_miss(64'h0000_0000_0000_1040, 20'd4, 16'd2, 64'h33);
      ack_now();
      send_beats(0, 7, 2, early);
      n_checks++;
      if (early != 0 || cacheUpdate_o !== 1'b1 || cacheUpdateLine_o !== exp_line()) begin
         n_fail++; $display("FAIL gaps_line: early=%0d upd=%b line=%h expected %h", early, cacheUpdate_o, cacheUpdateLine_o, exp_line());
      end
      step();
      n_checks++;
      if (cacheUpdate_o !== 1'b0) begin
         n_fail++; $display("FAIL gaps_single_pulse: upd=%b expected 0", cacheUpdate_o);
      end
   endtask

   task automatic test_drop_in_fill();
      int early;
      fill_beats(64'h5555_0000_0000_0000);
      present_miss(64'h80, 20'd7, 16'd3, 64'h44);
      ack_now();
      send_beats(0, 2, 0, early);
      present_miss(64'h1000, 20'd9, 16'd9, 64'h99);
      n_checks++;
      if (droppedMiss_o !== 1'b1 || busy_o !== 1'b1) begin
         n_fail++; $display("FAIL drop_fill_pulse: dropped=%b busy=%b expected 1/1", droppedMiss_o, busy_o);
      end
      step();
      n_checks++;
      if (droppedMiss_o !== 1'b0) begin
         n_fail++; $display("FAIL drop_fill_once: dropped=%b expected 0", droppedMiss_o);
      end
      send_beats(3, 7, 0, early);
      n_checks++;
      if (cacheUpdate_o !== 1'b1 || busy_o !== 1'b1 || cacheUpdateAddress_o !== 64'h80 ||
          cacheUpdatePid_o !== 20'd7 || cacheUpdateLine_o !== exp_line()) begin
         n_fail++; $display("FAIL drop_fill_update: upd=%b busy=%b addr=%h pid=%h", cacheUpdate_o, busy_o, cacheUpdateAddress_o, cacheUpdatePid_o);
      end
      step();
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++; $display("FAIL drop_fill_idle: busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_reset_mid_fill();
      int early;
      fill_beats(64'h9999_0000_0000_0000);
      present_miss(64'hC0, 20'd8, 16'd8, 64'h55);
      ack_now();
      send_beats(0, 3, 0, early);
      // Reset with a beat, an ack and a miss all present: none may take effect.
      reset_i = 1'b1; memDataValid_i = 1'b1; memData_i = 64'hBAD0_BAD0_BAD0_BAD0;
      memReqAck_i = 1'b1; cacheMiss_i = 1'b1; missedAddress_i = 64'h500;
      step();
      reset_i = 1'b0; memDataValid_i = 1'b0; memReqAck_i = 1'b0; cacheMiss_i = 1'b0;
      n_checks++;
      if ({busy_o, droppedMiss_o, memReq_o, cacheUpdate_o} !== 4'b0 ||
          cacheUpdateLine_o !== 512'h0 || cacheUpdateAddress_o !== 64'h0 ||
          cacheUpdatePid_o !== 20'h0 || cacheUpdateInstMajorId_o !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_mid_clear: flags=%b addr=%h pid=%h", {busy_o, droppedMiss_o, memReq_o, cacheUpdate_o}, cacheUpdateAddress_o, cacheUpdatePid_o);
      end
      step();
      n_checks++;
      if (busy_o !== 1'b0 || droppedMiss_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_miss_ignored: busy=%b dropped=%b expected 0/0", busy_o, droppedMiss_o);
      end
      fill_beats(64'h4040_0000_0000_0100);
      present_miss(64'h40, 20'd2, 16'd6, 64'h66);
      ack_now();
      send_beats(0, 7, 0, early);
      n_checks++;
      if (cacheUpdate_o !== 1'b1 || cacheUpdateLine_o !== exp_line() ||
          cacheUpdateAddress_o !== 64'h40 || cacheUpdatePid_o !== 20'd2) begin
         n_fail++; $display("FAIL reset_mid_refill: upd=%b line=%h addr=%h", cacheUpdate_o, cacheUpdateLine_o, cacheUpdateAddress_o);
      end
   endtask

   // Entered with the previous test's UPDATE cycle in progress.
   task automatic test_update_miss();
      int early;
      n_checks++;
      if (cacheUpdate_o !== 1'b1) begin
         n_fail++; $display("FAIL upd_miss_setup: upd=%b expected 1", cacheUpdate_o);
      end
      present_miss(64'h200, 20'd1, 16'd1, 64'h77);
      n_checks++;
      if (droppedMiss_o !== 1'b1 || busy_o !== 1'b0 || cacheUpdateAddress_o !== 64'h40) begin
         n_fail++; $display("FAIL upd_miss_drop: dropped=%b busy=%b addr=%h expected 1/0/40", droppedMiss_o, busy_o, cacheUpdateAddress_o);
      end
      present_miss(64'h30F, 20'd5, 16'd4, 64'h88);
      n_checks++;
      if (memReq_o !== 1'b1 || memReqAddress_o !== 64'h300 || droppedMiss_o !== 1'b0) begin
         n_fail++; $display("FAIL upd_miss_accept: memReq=%b addr=%h dropped=%b expected 1/300/0", memReq_o, memReqAddress_o, droppedMiss_o);
      end
      fill_beats(64'h3000_0000_0000_0000);
      ack_now();
      send_beats(0, 7, 0, early);
      n_checks++;
      if (cacheUpdate_o !== 1'b1 || cacheUpdatePid_o !== 20'd5 || cacheUpdateInstMajorId_o !== 64'h88) begin
         n_fail++; $display("FAIL upd_miss_fill: upd=%b pid=%h id=%h expected 1/5/88", cacheUpdate_o, cacheUpdatePid_o, cacheUpdateInstMajorId_o);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ack_delay();
      test_gaps();
      test_drop_in_fill();
      test_reset_mid_fill();
      test_update_miss();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
